serial_mul_arbiter: RTL and testbench

Round-robin arbiter that shares one `serial_mul` instance among `N_REQ` requesters. It accepts an operand pair from one requester at a time and pulses `start` to the multiplier. It waits for `data_ready` and returns the result to the granted requester, with a timeout guard against a hung multiplier. It sits between DSP/control clients and the single multiplier, so only one multiplication is ever in flight.

---
 rtl/serial_mul_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_serial_mul_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mul_arbiter.sv
// -----------------------------------------------------------------------------
// serial_mul_arbiter
//
// Shares a single serial multiplier among N_REQ requesters. One operand pair
// is accepted at a time (round-robin), a one-cycle start pulse is sent to the
// multiplier, and the product (or a timeout error) is returned to the
// requester that was granted. Only one multiplication is ever in flight.
//
// Parameters:
//   N_REQ          number of requesters (2..16)
//   N_BITS_A/B     operand widths (two's complement, passed through untouched)
//   N_BITS_RESULT  multiplier result width
//   TIMEOUT_CYCLES WAIT cycles tolerated before an error response
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   req_valid/ready    per-requester handshake; ready is one-hot, IDLE only
//   req_a/req_b        packed operands, requester i occupies slice i
//   resp_valid         one-hot, one-cycle response pulse to the grantee
//   resp_result/error  response payload, held until the next response
//   busy               high whenever the arbiter is not IDLE
//   mul_a/mul_b        latched operands to the multiplier
//   mul_start          one-cycle start pulse
//   mul_data_ready     multiplier done strobe
//   mul_result         multiplier product
// -----------------------------------------------------------------------------
module serial_mul_arbiter #(
  parameter int N_REQ          = 4,
  parameter int N_BITS_A       = 8,
  parameter int N_BITS_B       = 8,
  parameter int N_BITS_RESULT  = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*N_BITS_A-1:0]   req_a,
  input  logic [N_REQ*N_BITS_B-1:0]   req_b,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [N_BITS_RESULT-1:0]    resp_result,
  output logic                        resp_error,
  output logic                        busy,
  output logic [N_BITS_A-1:0]         mul_a,
  output logic [N_BITS_B-1:0]         mul_b,
  output logic                        mul_start,
  input  logic                        mul_data_ready,
  input  logic [N_BITS_RESULT-1:0]    mul_result
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                     state_reg, state_next;
  logic [ID_W-1:0]            grant_id_reg, grant_id_next;
  logic [ID_W-1:0]            last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic [N_BITS_A-1:0]        mul_a_reg, mul_a_next;
  logic [N_BITS_B-1:0]        mul_b_reg, mul_b_next;
  logic [N_BITS_RESULT-1:0]   result_reg, result_next;
  logic                       error_reg, error_next;

  // Per-requester operand views of the packed buses.
  logic [N_BITS_A-1:0] a_slice [N_REQ];
  logic [N_BITS_B-1:0] b_slice [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_slice[gi] = req_a[gi*N_BITS_A +: N_BITS_A];
      assign b_slice[gi] = req_b[gi*N_BITS_B +: N_BITS_B];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin winner: first valid requester starting just after the last
  // grant, wrapping modulo N_REQ. The last grant itself is checked last, so a
  // lone continuous requester is still served back to back.
  // ---------------------------------------------------------------------------
  logic            win_found;
  logic [ID_W-1:0] win_id;

  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(last_grant_reg) + off) % N_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Acceptance only ever happens in IDLE, so ready is gated by state.
  logic accept;
  assign accept = (state_reg == ST_IDLE) && win_found;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign req_ready[gi]  = accept && (win_id == ID_W'(gi));
      assign resp_valid[gi] = (state_reg == ST_RESP) && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

  assign busy        = (state_reg != ST_IDLE);
  assign mul_start   = (state_reg == ST_ISSUE);
  assign mul_a       = mul_a_reg;
  assign mul_b       = mul_b_reg;
  assign resp_result = result_reg;
  assign resp_error  = error_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    mul_a_next      = mul_a_reg;
    mul_b_next      = mul_b_reg;
    result_next     = result_reg;
    error_next      = error_reg;

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          mul_a_next      = a_slice[win_id];
          mul_b_next      = b_slice[win_id];
          grant_id_next   = win_id;
          last_grant_next = win_id;
          state_next      = ST_ISSUE;
        end
      end

      // Start pulse cycle; a data_ready here belongs to nothing and is ignored.
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end

      // The counter holds the number of WAIT cycles already spent without a
      // result, so the timeout fires in the (TIMEOUT_CYCLES+1)-th WAIT cycle.
      // A result arriving in that same cycle still wins over the timeout.
      ST_WAIT: begin
        if (mul_data_ready) begin
          result_next = mul_result;
          error_next  = 1'b0;
          state_next  = ST_RESP;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
          result_next = '0;
          error_next  = 1'b1;
          state_next  = ST_RESP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= ID_W'(N_REQ - 1);  // requester 0 first after reset
      cnt_reg        <= '0;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      result_reg     <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      mul_a_reg      <= mul_a_next;
      mul_b_reg      <= mul_b_next;
      result_reg     <= result_next;
      error_reg      <= error_next;
    end
  end

endmodule

// File: tb/tb_serial_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_mul_arbiter
//
// Transaction-level model of the arbiter: on each acceptance it schedules the
// start cycle, the multiplier's ready cycle and the response cycle with plain
// arithmetic, then compares all DUT outputs every cycle. The bench also plays
// the multiplier, answering with the product of the operands it expects.
// -----------------------------------------------------------------------------
module tb_serial_mul_arbiter;

  localparam int N_REQ = 4;
  localparam int NA    = 8;
  localparam int NB    = 8;
  localparam int NR    = 9;
  localparam int TO    = 16;

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*NA-1:0] req_a;
  logic [N_REQ*NB-1:0] req_b;
  logic [N_REQ-1:0]    resp_valid;
  logic [NR-1:0]       resp_result;
  logic                resp_error;
  logic                busy;
  logic [NA-1:0]       mul_a;
  logic [NB-1:0]       mul_b;
  logic                mul_start;
  logic                mul_data_ready;
  logic [NR-1:0]       mul_result;

  serial_mul_arbiter #(
    .N_REQ(N_REQ), .N_BITS_A(NA), .N_BITS_B(NB),
    .N_BITS_RESULT(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_error(resp_error),
    .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_data_ready(mul_data_ready), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Stimulus controls
  logic [N_REQ-1:0] rv = '0;
  logic [NA-1:0]    av [N_REQ];
  logic [NB-1:0]    bv [N_REQ];
  bit rst_v     = 1'b1;
  bit auto_drop = 1'b1;
  bit noise_en  = 1'b0;
  int lat_mode  = 9;   // <0 random, 0 never ready, >0 fixed latency after start

  // Model state
  bit            m_inflight  = 1'b0;
  int            m_start_cyc = -10;
  int            m_ready_cyc = -10;
  int            m_resp_cyc  = -10;
  int            m_grant     = 0;
  int            m_last      = N_REQ - 1;
  logic [NR-1:0] m_prod      = '0;
  logic [NR-1:0] m_resp_res  = '0;
  bit            m_resp_err  = 1'b0;
  logic [NR-1:0] e_res       = '0;
  bit            e_err       = 1'b0;
  logic [NA-1:0] e_a         = '0;
  logic [NB-1:0] e_b         = '0;

  // Observations of the DUT
  int            obs_resp_cnt  = 0;
  int            obs_resp_cyc  = 0;
  int            obs_acc_cyc   = 0;
  int            obs_start_cyc = 0;
  int            obs_id        = 0;
  logic [NR-1:0] obs_res       = '0;
  bit            obs_err       = 1'b0;
  int            grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, compare, then update the model.
  task automatic step();
    logic [N_REQ-1:0] exp_ready;
    logic [N_REQ-1:0] exp_rv;
    bit exp_busy;
    bit exp_start;
    int w;
    int L;
    int pa;
    int pb;
    int prod;
    @(negedge clk);
    cyc++;
    reset = rst_v;
    if (rst_v) begin
      m_inflight = 1'b0;
      m_last     = N_REQ - 1;
      e_res      = '0;
      e_err      = 1'b0;
      e_a        = '0;
      e_b        = '0;
    end
    if (m_inflight && cyc > m_resp_cyc) m_inflight = 1'b0;

    mul_data_ready = 1'b0;
    mul_result     = NR'($urandom);
    if (m_inflight && cyc == m_ready_cyc) begin
      mul_data_ready = 1'b1;
      mul_result     = m_prod;
    end else if (m_inflight && cyc == m_start_cyc && noise_en && $urandom_range(0, 1) == 1) begin
      mul_data_ready = 1'b1;
    end
    req_valid = rv;
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*NA +: NA] = av[i];
      req_b[i*NB +: NB] = bv[i];
    end

    exp_busy  = m_inflight;
    exp_start = m_inflight && (cyc == m_start_cyc);
    exp_rv    = '0;
    exp_ready = '0;
    w         = -1;
    if (m_inflight && cyc == m_resp_cyc) begin
      exp_rv[m_grant] = 1'b1;
      e_res = m_resp_res;
      e_err = m_resp_err;
    end
    if (!m_inflight) begin
      for (int o = 1; o <= N_REQ; o++) begin
        if (w < 0 && rv[(m_last + o) % N_REQ]) w = (m_last + o) % N_REQ;
      end
      if (w >= 0) exp_ready[w] = 1'b1;
    end

    #1;
    check("req_ready",   32'(req_ready),   32'(exp_ready));
    check("busy",        32'(busy),        32'(exp_busy));
    check("mul_start",   32'(mul_start),   32'(exp_start));
    check("resp_valid",  32'(resp_valid),  32'(exp_rv));
    check("resp_result", 32'(resp_result), 32'(e_res));
    check("resp_error",  32'(resp_error),  32'(e_err));
    check("mul_a",       32'(mul_a),       32'(e_a));
    check("mul_b",       32'(mul_b),       32'(e_b));

    if (resp_valid != '0) begin
      obs_resp_cnt++;
      obs_resp_cyc = cyc;
      obs_res      = resp_result;
      obs_err      = resp_error;
      obs_id       = -1;
      for (int i = 0; i < N_REQ; i++) if (resp_valid[i]) obs_id = i;
      grant_log.push_back(obs_id);
      $display("cycle %0d: response to requester %0d result=%0h error=%0b",
               cyc, obs_id, resp_result, resp_error);
    end
    if (mul_start) obs_start_cyc = cyc;
    if (!reset && (req_valid & req_ready) != '0) obs_acc_cyc = cyc;

    if (w >= 0 && !rst_v) begin
      m_inflight  = 1'b1;
      m_grant     = w;
      m_last      = w;
      m_start_cyc = cyc + 1;
      if (lat_mode < 0) L = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 20));
      else              L = lat_mode;
      pa     = $signed(av[w]);
      pb     = $signed(bv[w]);
      prod   = pa * pb;
      m_prod = NR'(prod);
      if (L != 0 && L <= TO + 1) begin
        m_ready_cyc = m_start_cyc + L;
        m_resp_cyc  = m_start_cyc + 1 + L;
        m_resp_res  = m_prod;
        m_resp_err  = 1'b0;
      end else begin
        m_ready_cyc = -10;
        m_resp_cyc  = m_start_cyc + TO + 2;
        m_resp_res  = '0;
        m_resp_err  = 1'b1;
      end
      e_a = av[w];
      e_b = bv[w];
      if (auto_drop) rv[w] = 1'b0;
    end
  endtask

  task automatic run_resps(input int n, input int max_cyc);
    int base;
    int c;
    base = obs_resp_cnt;
    c    = 0;
    while (obs_resp_cnt - base < n && c < max_cyc) begin
      step();
      c++;
    end
    check("resp_count", 32'(obs_resp_cnt - base), 32'(n));
  endtask

  task automatic pulse_reset();
    rst_v = 1'b1;
    step();
    step();
    rst_v = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    req_valid      = '0;
    req_a          = '0;
    req_b          = '0;
    mul_data_ready = 1'b0;
    mul_result     = '0;

    // Reset state: ready follows grant logic with requester 0 first.
    rv    = 4'b0110;
    rst_v = 1'b1;
    step();
    check("rst_ready_lit", 32'(req_ready), 32'd2);
    check("rst_busy_lit",  32'(busy),      32'd0);
    step();
    rv    = '0;
    rst_v = 1'b0;
    step();
    step();

    // Requester 0: 3*5 with a 9-cycle multiplier.
    av[0] = 8'd3; bv[0] = 8'd5; lat_mode = 9; rv = 4'b0001;
    run_resps(1, 40);
    check("t1_latency", 32'(obs_resp_cyc - obs_acc_cyc), 32'd11);
    check("t1_result",  32'(obs_res), 32'd15);
    check("t1_error",   32'(obs_err), 32'd0);
    check("t1_id",      32'(obs_id),  32'd0);

    // Requester 2: -4*7.
    av[2] = 8'hFC; bv[2] = 8'd7; lat_mode = 5; rv = 4'b0100;
    run_resps(1, 40);
    check("t2_result", 32'(obs_res), 32'h1E4);
    check("t2_id",     32'(obs_id),  32'd2);

    // Requesters 0 and 2 together after reset: 0 first, then 2.
    pulse_reset();
    grant_log.delete();
    av[0] = 8'd12; bv[0] = 8'hF3; av[2] = 8'h80; bv[2] = 8'h80;
    lat_mode = 3; rv = 4'b0101;
    run_resps(2, 60);
    check("t3_first",  32'(grant_log[0]), 32'd0);
    check("t3_second", 32'(grant_log[1]), 32'd2);

    // All four requesting continuously for eight operations.
    pulse_reset();
    grant_log.delete();
    for (int i = 0; i < N_REQ; i++) begin
      av[i] = NA'($urandom);
      bv[i] = NB'($urandom);
    end
    auto_drop = 1'b0; lat_mode = 3; rv = 4'b1111;
    run_resps(8, 120);
    for (int i = 0; i < 8; i++) check("t4_order", 32'(grant_log[i]), 32'(i % 4));
    rv = '0; auto_drop = 1'b1;
    step();

    // Hung multiplier: error response mul_start+18, then normal service.
    av[1] = 8'd77; bv[1] = 8'd3; lat_mode = 0; rv = 4'b0010;
    run_resps(1, 40);
    check("t5_delay",  32'(obs_resp_cyc - obs_start_cyc), 32'd18);
    check("t5_error",  32'(obs_err), 32'd1);
    check("t5_result", 32'(obs_res), 32'd0);
    av[0] = 8'd9; bv[0] = 8'd9; lat_mode = 4; rv = 4'b0001;
    run_resps(1, 30);
    check("t5_next_error",  32'(obs_err), 32'd0);
    check("t5_next_result", 32'(obs_res), 32'd81);

    // Asynchronous reset while waiting on the multiplier.
    av[0] = 8'd6; bv[0] = 8'd6; lat_mode = 0; rv = 4'b0001;
    for (int i = 0; i < 4; i++) step();
    check("t6_busy_pre", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_busy",        32'(busy),        32'd0);
    check("t6_resp_valid",  32'(resp_valid),  32'd0);
    check("t6_mul_start",   32'(mul_start),   32'd0);
    check("t6_mul_a",       32'(mul_a),       32'd0);
    check("t6_mul_b",       32'(mul_b),       32'd0);
    check("t6_resp_result", 32'(resp_result), 32'd0);
    check("t6_resp_error",  32'(resp_error),  32'd0);
    rst_v = 1'b1;
    rv    = 4'b1011;
    lat_mode = 6;
    step();
    step();
    rst_v = 1'b0;
    step();
    check("t6_prio", 32'(req_ready), 32'd1);
    grant_log.delete();
    run_resps(1, 40);
    check("t6_first_id", 32'(obs_id), 32'd0);

    // Randomized traffic with random latencies, timeouts and ISSUE noise.
    lat_mode = -1; noise_en = 1'b1; auto_drop = 1'b1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            rv[i] = 1'b1;
            av[i] = NA'($urandom);
            bv[i] = NB'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
      end
      step();
    end
    rv = '0;
    for (int n = 0; n < 40; n++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
